picorv32_mem_bridge: RTL and testbench
======================================

// Module: picorv32_mem_bridge
// PURPOSE
//  Bridges the picorv32 native memory interface (mem_valid/mem_ready) to the dual-port
//  synchronous ram in the SQED demo top. Data accesses use ram port A; instruction fetches
//  use port B. A cutpoint override lets the QED harness substitute fetched instructions.
//  Bounded, deterministic latency; always completes a handshake, even for bad addresses.
// PARAMETERS
//  ADDR_W      5   word-address width of ram (DEPTH = 2**ADDR_W words)
//  RD_LATENCY  1   ram read latency in cycles, legal 1..4
// PORTS
//  clk              in   1       single clock, all logic posedge
//  reset            in   1       synchronous, active-high
//  mem_valid        in   1       cpu request valid
//  mem_instr        in   1       request is instruction fetch
//  mem_addr         in   32      byte address (bits [1:0] ignored)
//  mem_wdata        in   32      write data
//  mem_wstrb        in   4       byte write strobes; 0 = read
//  mem_ready        out  1       one-cycle completion pulse
//  mem_rdata        out  32      read data, valid while mem_ready=1
//  instr_ovr_valid  in   1       cutpoint: replace fetch data
//  instr_ovr        in   32      cutpoint instruction word
//  ram_addra        out  ADDR_W  port A word address (data)
//  ram_dina         out  32      port A write data
//  ram_wea          out  4       port A byte write enables
//  ram_douta        in   32      port A read data
//  ram_addrb        out  ADDR_W  port B word address (fetch)
//  ram_doutb        in   32      port B read data
//  oob_err          out  1       sticky: access outside DEPTH seen
// BEHAVIOUR
//  Reset: state=IDLE. Reset values: mem_ready=0, mem_rdata=0, ram_addra/ram_addrb=0,
//   ram_dina=0, ram_wea=0, oob_err=0. ram_wea is forced 0 in any cycle with reset=1,
//   so no write commits during reset.
//  FSM IDLE -> ISSUE -> (WAIT, reads only) -> RESP -> IDLE.
//  - IDLE: on mem_valid=1, latch word=mem_addr[ADDR_W+1:2], wdata, wstrb, instr,
//    oob=|mem_addr[31:ADDR_W+2]. If instr=1 and instr_ovr_valid=1, also latch ovr_hit=1
//    and instr_ovr. Go to ISSUE. Requests are accepted only in IDLE.
//  - ISSUE (1 cycle): drive the ram port from the latched word.
//    - Write: ram_addra=word, ram_dina=wdata, ram_wea=wstrb (0 if oob). Go to RESP.
//    - Data read: ram_addra=word. Instruction fetch: ram_addrb=word. Go to WAIT.
//  - WAIT: lasts RD_LATENCY cycles (down-counter). In the last cycle capture into rdata_q:
//    - oob read: 0
//    - ovr_hit: latched instr_ovr
//    - fetch: ram_doutb
//    - data read: ram_douta
//  - RESP (1 cycle): mem_ready=1, mem_rdata=rdata_q (0 for writes). Go to IDLE.
//  - Latency from accept edge: write ready at +2, read ready at +2+RD_LATENCY.
//  - ram addresses hold their last value outside ISSUE/WAIT. ram_wea=0 outside ISSUE.
//  - mem_ready is never asserted for two consecutive cycles; mem_rdata=0 when not ready.
//  - mem_valid dropping mid-transaction: the transaction still completes with a ready pulse.
//    Input changes after accept are ignored (everything is latched).
//  - oob: no ram write, read data=0, oob_err set and held until reset. Handshake completes normally.
//  - Reset mid-transaction: abort to IDLE, no ready pulse, no pending write.
//  - Override latched only at accept; instr_ovr_valid is ignored on data accesses.
// STRUCTURE
//  - Package picorv32_mem_pkg: XLEN=32, WSTRB_W=4, FSM state encoding, RD_LATENCY bounds.
//  - Single module; latency counter and request register are inline. No sub-module needed.
// TESTING (ADDR_W=5, RD_LATENCY=1)
//  1. Reset 2 cycles, all inputs random -> all outputs 0, no ram_wea activity.
//  2. Write addr 0x10, wdata 0xDEADBEEF, wstrb 4'b0011
//     -> ISSUE cycle: ram_addra=4, ram_dina=DEADBEEF, ram_wea=0011; mem_ready pulse at accept+2.
//  3. Data read addr 0x10, ram_douta=0x1234BEEF
//     -> mem_ready at accept+3 for 1 cycle, mem_rdata=0x1234BEEF; ram_wea stays 0.
//  4. Fetch addr 0x8, instr_ovr_valid=1, instr_ovr=0x00000013, ram_doutb=0xFFFFFFFF
//     -> ram_addrb=2, mem_rdata=0x00000013.
//  5. Write addr 0x100 (word 64) -> ram_wea=0 throughout, ready at +2, oob_err=1 and still 1
//     after 3 later good accesses.
//  6. Reset during WAIT of a read -> no mem_ready; the next read to addr 0x4 completes at accept+3.

Source files
------------

// File: rtl/picorv32_mem_pkg.sv
// Shared widths, FSM encoding and latency bounds for the picorv32 memory bridge.
package picorv32_mem_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned WSTRB_W        = 4;
    localparam int unsigned RD_LATENCY_MIN = 1;
    localparam int unsigned RD_LATENCY_MAX = 4;
    localparam int unsigned CNT_W          = 3;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } bridge_state_e;

endpackage

// File: rtl/picorv32_mem_bridge.sv
// Bridges the picorv32 native memory handshake to a dual-port synchronous ram:
// data on port A, instruction fetch on port B, with a fetch-override cutpoint.
module picorv32_mem_bridge
    import picorv32_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mem_valid,
    input  logic               mem_instr,
    input  logic [XLEN-1:0]    mem_addr,
    input  logic [XLEN-1:0]    mem_wdata,
    input  logic [WSTRB_W-1:0] mem_wstrb,
    output logic               mem_ready,
    output logic [XLEN-1:0]    mem_rdata,
    input  logic               instr_ovr_valid,
    input  logic [XLEN-1:0]    instr_ovr,
    output logic [ADDR_W-1:0]  ram_addra,
    output logic [XLEN-1:0]    ram_dina,
    output logic [WSTRB_W-1:0] ram_wea,
    input  logic [XLEN-1:0]    ram_douta,
    output logic [ADDR_W-1:0]  ram_addrb,
    input  logic [XLEN-1:0]    ram_doutb,
    output logic               oob_err
);

    bridge_state_e      state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               is_write_q;
    logic               instr_q;
    logic               oob_q;
    logic               ovr_hit_q;
    logic [XLEN-1:0]    ovr_q;
    logic [WSTRB_W-1:0] wea_q;

    logic [ADDR_W-1:0]  req_word;
    logic               req_oob;

    assign req_word = mem_addr[ADDR_W+1:2];
    assign req_oob  = |mem_addr[XLEN-1:ADDR_W+2];

    // Mask keeps a write from committing in the first cycle reset is raised.
    assign ram_wea = reset ? '0 : wea_q;

    // Ram ports are loaded on the accept edge so they are stable for the whole ISSUE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            is_write_q <= 1'b0;
            instr_q    <= 1'b0;
            oob_q      <= 1'b0;
            ovr_hit_q  <= 1'b0;
            ovr_q      <= '0;
            wea_q      <= '0;
            mem_ready  <= 1'b0;
            mem_rdata  <= '0;
            ram_addra  <= '0;
            ram_addrb  <= '0;
            ram_dina   <= '0;
            oob_err    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    mem_ready <= 1'b0;
                    mem_rdata <= '0;
                    if (mem_valid) begin
                        is_write_q <= |mem_wstrb;
                        instr_q    <= mem_instr;
                        oob_q      <= req_oob;
                        ovr_hit_q  <= mem_instr && instr_ovr_valid;
                        ovr_q      <= instr_ovr;
                        if (req_oob) begin
                            oob_err <= 1'b1;
                        end
                        if (|mem_wstrb) begin
                            ram_addra <= req_word;
                            ram_dina  <= mem_wdata;
                            wea_q     <= req_oob ? '0 : mem_wstrb;
                        end else if (mem_instr) begin
                            ram_addrb <= req_word;
                        end else begin
                            ram_addra <= req_word;
                        end
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    wea_q <= '0;
                    if (is_write_q) begin
                        mem_ready <= 1'b1;
                        mem_rdata <= '0;
                        state_q   <= StResp;
                    end else begin
                        cnt_q   <= CNT_W'(RD_LATENCY - 1);
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        if (oob_q) begin
                            mem_rdata <= '0;
                        end else if (ovr_hit_q) begin
                            mem_rdata <= ovr_q;
                        end else if (instr_q) begin
                            mem_rdata <= ram_doutb;
                        end else begin
                            mem_rdata <= ram_douta;
                        end
                        mem_ready <= 1'b1;
                        state_q   <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StResp: begin
                    mem_ready <= 1'b0;
                    mem_rdata <= '0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_picorv32_mem_bridge.sv
// Directed self-checking bench for picorv32_mem_bridge (ADDR_W=5, RD_LATENCY=1).
module tb_picorv32_mem_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        instr_ovr_valid;
    logic [31:0] instr_ovr;
    logic [4:0]  ram_addra;
    logic [31:0] ram_dina;
    logic [3:0]  ram_wea;
    logic [31:0] ram_douta;
    logic [4:0]  ram_addrb;
    logic [31:0] ram_doutb;
    logic        oob_err;

    int checks = 0;
    int errors = 0;

    picorv32_mem_bridge #(.ADDR_W(5), .RD_LATENCY(1)) dut (
        .clk             (clk),
        .reset           (reset),
        .mem_valid       (mem_valid),
        .mem_instr       (mem_instr),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_wstrb       (mem_wstrb),
        .mem_ready       (mem_ready),
        .mem_rdata       (mem_rdata),
        .instr_ovr_valid (instr_ovr_valid),
        .instr_ovr       (instr_ovr),
        .ram_addra       (ram_addra),
        .ram_dina        (ram_dina),
        .ram_wea         (ram_wea),
        .ram_douta       (ram_douta),
        .ram_addrb       (ram_addrb),
        .ram_doutb       (ram_doutb),
        .oob_err         (oob_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one cycle (caller guarantees IDLE), then scrambles inputs.
    task automatic accept(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic instr);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        mem_instr = instr;
        step();
        mem_valid       = 1'b0;
        mem_addr        = 32'hFFFF_FFFC;
        mem_wdata       = 32'h5555_AAAA;
        mem_wstrb       = 4'hF;
        mem_instr       = ~instr;
        instr_ovr_valid = 1'b0;
        instr_ovr       = 32'h0BAD_0BAD;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mem_valid       = 1'($urandom);
            mem_instr       = 1'($urandom);
            mem_addr        = $urandom;
            mem_wdata       = $urandom;
            mem_wstrb       = 4'($urandom);
            instr_ovr_valid = 1'($urandom);
            instr_ovr       = $urandom;
            ram_douta       = $urandom;
            ram_doutb       = $urandom;
            step();
            checks++;
            if ({mem_ready, mem_rdata, ram_addra, ram_addrb, ram_dina, ram_wea, oob_err} !== '0)
            begin
                errors++;
                $display("FAIL reset_outputs cycle %0d got rdy=%b rdata=%h a=%h b=%h din=%h we=%b oob=%b want all 0",
                         i, mem_ready, mem_rdata, ram_addra, ram_addrb, ram_dina, ram_wea, oob_err);
            end
        end
        reset           = 1'b0;
        mem_valid       = 1'b0;
        mem_instr       = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        mem_wstrb       = '0;
        instr_ovr_valid = 1'b0;
        instr_ovr       = '0;
        step();
    endtask

    task automatic test_write();
        accept(32'h10, 32'hDEAD_BEEF, 4'b0011, 1'b0);
        checks++;
        if (ram_addra !== 5'd4 || ram_dina !== 32'hDEAD_BEEF || ram_wea !== 4'b0011 ||
            mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL write_issue got a=%h din=%h we=%b rdy=%b want a=4 din=deadbeef we=0011 rdy=0",
                     ram_addra, ram_dina, ram_wea, mem_ready);
        end
        step();
        checks++;
        if (mem_ready !== 1'b1 || mem_rdata !== 32'h0 || ram_wea !== 4'b0) begin
            errors++;
            $display("FAIL write_resp got rdy=%b rdata=%h we=%b want rdy=1 rdata=0 we=0",
                     mem_ready, mem_rdata, ram_wea);
        end
        step();
        checks++;
        if (mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL write_ready_pulse got rdy=%b want 0", mem_ready);
        end
    endtask

    // Read with RD_LATENCY=1: ready observed high two cycles after ISSUE.
    task automatic run_read(input string name, input logic [31:0] addr, input logic instr,
                            input logic [31:0] exp);
        accept(addr, 32'h0, 4'b0, instr);
        step();
        checks++;
        if (mem_ready !== 1'b0 || ram_wea !== 4'b0) begin
            errors++;
            $display("FAIL %s_wait got rdy=%b we=%b want rdy=0 we=0", name, mem_ready, ram_wea);
        end
        step();
        checks++;
        if (mem_ready !== 1'b1 || mem_rdata !== exp) begin
            errors++;
            $display("FAIL %s_resp got rdy=%b rdata=%h want rdy=1 rdata=%h",
                     name, mem_ready, mem_rdata, exp);
        end
        step();
        checks++;
        if (mem_ready !== 1'b0 || mem_rdata !== 32'h0) begin
            errors++;
            $display("FAIL %s_idle got rdy=%b rdata=%h want 0 0", name, mem_ready, mem_rdata);
        end
    endtask

    task automatic test_read();
        ram_douta = 32'h1234_BEEF;
        run_read("data_read", 32'h10, 1'b0, 32'h1234_BEEF);
        checks++;
        if (ram_addra !== 5'd4) begin
            errors++;
            $display("FAIL data_read_addra got %h want 4", ram_addra);
        end
    endtask

    task automatic test_fetch();
        ram_doutb       = 32'hFFFF_FFFF;
        instr_ovr_valid = 1'b1;
        instr_ovr       = 32'h0000_0013;
        run_read("fetch_ovr", 32'h8, 1'b1, 32'h0000_0013);
        checks++;
        if (ram_addrb !== 5'd2 || ram_addra !== 5'd4) begin
            errors++;
            $display("FAIL fetch_addr got b=%h a=%h want b=2 a=4", ram_addrb, ram_addra);
        end
        ram_doutb = 32'hA5A5_0F0F;
        run_read("fetch_plain", 32'h1C, 1'b1, 32'hA5A5_0F0F);
        // Override requested on a data access must be ignored.
        ram_douta       = 32'h7777_1111;
        instr_ovr_valid = 1'b1;
        instr_ovr       = 32'h0000_0013;
        run_read("data_no_ovr", 32'h0C, 1'b0, 32'h7777_1111);
    endtask

    task automatic test_oob();
        accept(32'h100, 32'hCAFE_CAFE, 4'b1111, 1'b0);
        checks++;
        if (ram_wea !== 4'b0 || oob_err !== 1'b1) begin
            errors++;
            $display("FAIL oob_issue got we=%b oob=%b want we=0 oob=1", ram_wea, oob_err);
        end
        step();
        checks++;
        if (mem_ready !== 1'b1 || ram_wea !== 4'b0) begin
            errors++;
            $display("FAIL oob_resp got rdy=%b we=%b want rdy=1 we=0", mem_ready, ram_wea);
        end
        step();
        ram_douta = 32'h1357_9BDF;
        run_read("oob_read", 32'h200, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            run_read("post_oob", 32'h4, 1'b0, 32'h1357_9BDF);
            checks++;
            if (oob_err !== 1'b1) begin
                errors++;
                $display("FAIL oob_sticky access %0d got %b want 1", i, oob_err);
            end
        end
    endtask

    task automatic test_reset_mid();
        ram_douta = 32'h0101_0202;
        accept(32'h4, 32'h0, 4'b0, 1'b0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem_ready !== 1'b0 || oob_err !== 1'b0) begin
                errors++;
                $display("FAIL reset_abort cycle %0d got rdy=%b oob=%b want 0 0",
                         i, mem_ready, oob_err);
            end
            step();
        end
        ram_douta = 32'hCAFE_F00D;
        run_read("after_abort", 32'h4, 1'b0, 32'hCAFE_F00D);
        // Reset raised during a write's ISSUE cycle blocks the strobe immediately.
        accept(32'h14, 32'h1111_2222, 4'b1111, 1'b0);
        reset = 1'b1;
        #1;
        checks++;
        if (ram_wea !== 4'b0) begin
            errors++;
            $display("FAIL reset_masks_wea got %b want 0", ram_wea);
        end
        step();
        reset = 1'b0;
        step();
        checks++;
        if (mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_write_abort got rdy=%b want 0", mem_ready);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_fetch();
        test_oob();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
